apb_reg_completer: RTL and testbench
====================================

# apb_reg_completer

APB completer (slave) that answers transfers issued by the team's APB initiators: a word-indexed register file with a read-only ID word, a read-only completed-transfer counter, programmable wait states and error response on illegal accesses. Sits on the APB bus opposite the compute initiator and is the bus target in block-level simulation and on-chip.

## Interface
- DEPTH, 16: number of 32-bit words addressed (4..256); paddr_i is a word index, not a byte address
- ID_VALUE, 32'hA5B0_0001: constant returned at index 0
- pclk_i  in  1  single clock, all logic on rising edge
- presetn_i  in  1  reset, synchronous, active-low
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- paddr_i  in  8  word index
- pwrite_i  in  1  1 = write, 0 = read
- pwdata_i  in  32  write data
- wait_cfg_i  in  4  wait states inserted per transfer (0..15); sampled at setup phase
- prdata_o  out  32  read data, valid only with pready_o on a read
- pready_o  out  1  transfer completes this cycle
- pslverr_o  out  1  error response, valid only with pready_o

## Operation
- Register map: 0 = ID (RO, ID_VALUE); 1 = XFER_CNT (RO, completed transfers incl. errored, 32-bit, wraps FFFF_FFFF -> 0); 2..DEPTH-1 = RW data words, reset to 0.
- Error (pslverr_o=1 with pready_o): index >= DEPTH; write to index 0 or 1. Errored write changes no register; errored read returns prdata_o=0.
- States: IDLE, ACCESS.
- IDLE: psel_i=1 & penable_i=0 -> load wait_cnt <= wait_cfg_i, latch paddr/pwrite, go ACCESS. penable_i=1 without a preceding setup is ignored (no pready).
- ACCESS: while psel_i & penable_i & wait_cnt!=0 -> decrement. pready_o = psel_i & penable_i & wait_cnt==0 (combinational from state/counter). On that cycle: write commits at clock edge (if legal), XFER_CNT increments, state -> IDLE.
- ACCESS with psel_i=0: abort -> IDLE, no write, no count, no pready.
- Back-to-back: setup of next transfer arrives in cycle after pready; handled from IDLE with no bubble.
- Read of XFER_CNT returns value before the increment caused by that read.
- prdata_o, pslverr_o forced 0 whenever pready_o=0.

## Timing
- Reset: state IDLE, wait_cnt 0, RW words 0, XFER_CNT 0; prdata_o=0, pready_o=0, pslverr_o=0 in the cycle after reset sampled low and throughout reset.
- Reset asserted mid-transfer: transfer dropped, no write, outputs 0 next cycle.
- Latency, wait_cfg_i=N: setup cycle T, pready_o high in cycle T+1+N; minimum 2 cycles per transfer.
- Write data becomes readable by a transfer whose setup is in the cycle after completion.
- wait_cfg_i changes mid-transfer do not affect that transfer.

## Configuration
- APB_WAIT_STATES_EN defined: wait_cfg_i honoured as above.
- Undefined: wait_cfg_i ignored, wait counter not built; pready_o = psel_i & penable_i in ACCESS (always zero-wait, 2-cycle transfers). All other behaviour identical.

## Structure
- Package apb_reg_pkg: state enum (IDLE, ACCESS), index constants IDX_ID=0, IDX_XFER_CNT=1, default ID_VALUE, data/address width constants (32, 8).
- One sub-module apb_regfile: DEPTH-2 RW words, synchronous write port, combinational read port, synchronous active-low clear. Decode, error logic, FSM and XFER_CNT stay in the top.

## Test plan
- Reset, then read index 0, wait 0 -> pready in 2nd cycle, prdata_o=A5B0_0001, pslverr_o=0.
- Write 0xDEAD_BEEF to index 5 then read index 5, wait_cfg_i=3 -> each pready 4 cycles after setup; read returns DEAD_BEEF; XFER_CNT read afterwards = 2.
- Write index 1 and read index 20 (DEPTH=16) -> both pslverr_o=1, XFER_CNT unchanged value except +2, read data 0.
- Setup to index 3 write 0x1234, psel_i dropped during wait states -> no pready, index 3 still 0, XFER_CNT unchanged.
- Assert presetn_i low during a 10-wait write -> outputs 0 next cycle, all words 0 after release.
- Macro undefined, wait_cfg_i=15 -> every transfer completes in 2 cycles.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register completer.
package apb_reg_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 8;
    localparam int IDX_ID       = 0;
    localparam int IDX_XFER_CNT = 1;

    localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/apb_regfile.sv
// Read/write word storage behind the APB completer. It covers indices 2..DEPTH-1.
// The write port is synchronous and the read port is combinational.
module apb_regfile
    import apb_reg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int NW = DEPTH - 2;
    localparam int IW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [NW];
    logic [ADDR_W:0]   w_off;
    logic              w_hit;
    logic [IW-1:0]     w_idx;

    // Bus index 2 maps to storage slot 0. Indices outside the storage range miss.
    assign w_off = {1'b0, i_addr} - (ADDR_W+1)'(2);
    assign w_hit = (i_addr >= ADDR_W'(2)) && (w_off < (ADDR_W+1)'(NW));
    assign w_idx = w_off[IW-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NW; i++) r_mem[i] <= '0;
        end else if (i_we && w_hit) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    assign o_rdata = w_hit ? r_mem[w_idx] : '0;

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer: ID word, transfer counter, RW register file, wait states, error response.
// The APB_WAIT_STATES_EN macro enables the programmable wait states. Without it, every transfer is zero-wait.
module apb_reg_completer
    import apb_reg_pkg::*;
#(
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [3:0]        wait_cfg_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_xfer_cnt;
    logic              w_setup, w_ready, w_wait_zero, w_err, w_we;
    logic [DATA_W-1:0] w_rf_rdata, w_rdata;

    assign w_setup = (r_state == IDLE) && psel_i && !penable_i;

`ifdef APB_WAIT_STATES_EN
    logic [3:0] r_wait_cnt, w_wait_nxt;
    assign w_wait_zero = (r_wait_cnt == 4'd0);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^wait_cfg_i;
    assign w_wait_zero  = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
`ifdef APB_WAIT_STATES_EN
        w_wait_nxt  = r_wait_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    w_state_nxt = ACCESS;
`ifdef APB_WAIT_STATES_EN
                    w_wait_nxt  = wait_cfg_i;
`endif
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    w_state_nxt = IDLE;
                end else if (penable_i) begin
                    if (w_wait_zero) begin
                        w_ready     = 1'b1;
                        w_state_nxt = IDLE;
                    end
`ifdef APB_WAIT_STATES_EN
                    else begin
                        w_wait_nxt = r_wait_cnt - 4'd1;
                    end
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_xfer_cnt <= '0;
`ifdef APB_WAIT_STATES_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef APB_WAIT_STATES_EN
            r_wait_cnt <= w_wait_nxt;
`endif
            if (w_setup) begin
                r_addr  <= paddr_i;
                r_write <= pwrite_i;
            end
            if (pready_o) r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    // Out-of-range indices and writes to the two read-only words complete with an error.
    assign w_err = ({1'b0, r_addr} >= (ADDR_W+1)'(DEPTH)) ||
                   (r_write && (r_addr <= ADDR_W'(IDX_XFER_CNT)));
    assign w_we  = pready_o && r_write && !w_err;

    apb_regfile #(.DEPTH(DEPTH)) u_regfile (
        .i_clk   (pclk_i),
        .i_rst_n (presetn_i),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (pwdata_i),
        .o_rdata (w_rf_rdata)
    );

    always_comb begin
        case (r_addr)
            ADDR_W'(IDX_ID):       w_rdata = ID_VALUE;
            ADDR_W'(IDX_XFER_CNT): w_rdata = r_xfer_cnt;
            default:               w_rdata = w_rf_rdata;
        endcase
    end

    // Gating with reset keeps a transfer that is cut off by reset from completing on the bus.
    assign pready_o  = w_ready && presetn_i;
    assign pslverr_o = pready_o && w_err;
    assign prdata_o  = (pready_o && !r_write && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed, table-driven bench for apb_reg_completer. Expected latencies follow APB_WAIT_STATES_EN.
module tb_apb_reg_completer;

    logic        pclk_i = 1'b0;
    logic        presetn_i, psel_i, penable_i, pwrite_i;
    logic [7:0]  paddr_i;
    logic [31:0] pwdata_i, prdata_o;
    logic [3:0]  wait_cfg_i;
    logic        pready_o, pslverr_o;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    apb_reg_completer #(.DEPTH(16), .ID_VALUE(ID)) dut (
        .pclk_i(pclk_i), .presetn_i(presetn_i), .psel_i(psel_i), .penable_i(penable_i),
        .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .wait_cfg_i(wait_cfg_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o)
    );

    always #5 pclk_i = ~pclk_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic int exp_lat(input logic [3:0] cfg);
`ifdef APB_WAIT_STATES_EN
        return int'(cfg) + 1;
`else
        return 1 + 0 * int'(cfg);
`endif
    endfunction

    // One transfer: setup, then access until pready or timeout. psel_i is left high, so a following call is back-to-back.
    task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] wd, input logic [3:0] cfg,
                        output logic [31:0] rd, output logic err, output int lat, output logic noise);
        @(negedge pclk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = w; pwdata_i = wd; wait_cfg_i = cfg;
        #1;
        noise = pready_o | (|prdata_o) | pslverr_o;
        rd = '0; err = 1'b0; lat = -1;
        @(negedge pclk_i);
        penable_i = 1'b1;
        wait_cfg_i = ~cfg;
        for (int i = 1; i <= 40; i++) begin
            #1;
            if (pready_o) begin
                rd = prdata_o; err = pslverr_o; lat = i;
                break;
            end
            noise = noise | (|prdata_o) | pslverr_o;
            @(negedge pclk_i);
        end
    endtask

    task automatic go_idle();
        @(negedge pclk_i);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic err, noise; int lat;
        xfer(a, 1'b0, 32'h0, 4'd0, rd, err, lat, noise);
        chk({name, "_data"}, rd, exp);
        chk({name, "_err"}, {31'b0, err}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  cfg;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] rd; logic err, noise, seen; int lat;

        tbl[0]  = '{8'd0,  1'b0, 32'h0,         4'd0,  ID,            1'b0};
        tbl[1]  = '{8'd5,  1'b1, 32'hDEAD_BEEF, 4'd3,  32'h0,         1'b0};
        tbl[2]  = '{8'd5,  1'b0, 32'h0,         4'd3,  32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{8'd1,  1'b0, 32'h0,         4'd0,  32'd3,         1'b0};
        tbl[4]  = '{8'd1,  1'b1, 32'h5555_5555, 4'd1,  32'h0,         1'b1};
        tbl[5]  = '{8'd20, 1'b0, 32'h0,         4'd2,  32'h0,         1'b1};
        tbl[6]  = '{8'd1,  1'b0, 32'h0,         4'd0,  32'd6,         1'b0};
        tbl[7]  = '{8'd0,  1'b1, 32'h1111_1111, 4'd0,  32'h0,         1'b1};
        tbl[8]  = '{8'd0,  1'b0, 32'h0,         4'd1,  ID,            1'b0};
        tbl[9]  = '{8'd15, 1'b1, 32'h0000_00FF, 4'd15, 32'h0,         1'b0};
        tbl[10] = '{8'd15, 1'b0, 32'h0,         4'd15, 32'h0000_00FF, 1'b0};
        tbl[11] = '{8'd16, 1'b1, 32'h7777_7777, 4'd2,  32'h0,         1'b1};
        tbl[12] = '{8'd2,  1'b0, 32'h0,         4'd0,  32'h0,         1'b0};
        tbl[13] = '{8'd1,  1'b0, 32'h0,         4'd4,  32'd13,        1'b0};

        presetn_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; paddr_i = '0;
        pwrite_i = 1'b0; pwdata_i = '0; wait_cfg_i = '0;
        repeat (2) @(negedge pclk_i);
        #1;
        chk("rst_pready", {31'b0, pready_o}, 32'd0);
        chk("rst_prdata", prdata_o, 32'd0);
        chk("rst_pslverr", {31'b0, pslverr_o}, 32'd0);
        @(negedge pclk_i);
        presetn_i = 1'b1;

        // The vector table runs back-to-back. Its XFER_CNT expectations count every completion before the read.
        foreach (tbl[k]) begin
            xfer(tbl[k].a, tbl[k].w, tbl[k].wd, tbl[k].cfg, rd, err, lat, noise);
            chk($sformatf("v%0d_rdata", k), rd, tbl[k].erd);
            chk($sformatf("v%0d_err", k), {31'b0, err}, {31'b0, tbl[k].eerr});
            chk($sformatf("v%0d_lat", k), lat, exp_lat(tbl[k].cfg));
            chk($sformatf("v%0d_quiet", k), {31'b0, noise}, 32'd0);
        end
        go_idle();

        // penable without a preceding setup must be ignored.
        @(negedge pclk_i);
        psel_i = 1'b1; penable_i = 1'b1; paddr_i = 8'd0; pwrite_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 seen = seen | pready_o;
            @(negedge pclk_i);
        end
        chk("nosetup_pready", {31'b0, seen}, 32'd0);
        psel_i = 1'b0; penable_i = 1'b0;

        // Abort: psel_i drops before completion.
        @(negedge pclk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 8'd3; pwrite_i = 1'b1;
        pwdata_i = 32'h0000_1234; wait_cfg_i = 4'd5;
        seen = 1'b0;
`ifdef APB_WAIT_STATES_EN
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk_i);
            penable_i = 1'b1;
            #1 seen = seen | pready_o;
        end
`endif
        @(negedge pclk_i);
        psel_i = 1'b0; penable_i = 1'b0;
        #1 seen = seen | pready_o;
        chk("abort_pready", {31'b0, seen}, 32'd0);
        rd_chk("abort_idx3", 8'd3, 32'd0);
        rd_chk("abort_cnt", 8'd1, 32'd15);
        go_idle();

        // Reset asserted during a long write.
        @(negedge pclk_i);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 8'd4; pwrite_i = 1'b1;
        pwdata_i = 32'h0000_CAFE; wait_cfg_i = 4'd10;
        @(negedge pclk_i);
        penable_i = 1'b1; presetn_i = 1'b0;
        @(negedge pclk_i);
        #1;
        chk("midrst_pready", {31'b0, pready_o}, 32'd0);
        chk("midrst_prdata", prdata_o, 32'd0);
        chk("midrst_pslverr", {31'b0, pslverr_o}, 32'd0);
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge pclk_i);
        presetn_i = 1'b1;
        rd_chk("post_idx4", 8'd4, 32'd0);
        rd_chk("post_idx5", 8'd5, 32'd0);
        rd_chk("post_idx15", 8'd15, 32'd0);
        rd_chk("post_cnt", 8'd1, 32'd3);
        rd_chk("post_id", 8'd0, ID);
        go_idle();

        repeat (2) @(negedge pclk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
